// File: rtl/regbus_if.sv
// Register-file access bus: read request/response, per-register tri-state
// enables for the shared A/B read buses, and the write strobe/data path.
interface regbus_if;
   logic        rd_valid;
   logic        rd_ready;
   logic [4:0]  ra;
   logic [4:0]  rb;
   logic [31:0] asel;
   logic [31:0] bsel;
   logic [31:0] abus;
   logic [31:0] bbus;
   logic        rd_data_valid;
   logic [31:0] a_data;
   logic [31:0] b_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [4:0]  rw;
   logic [31:0] wdata;
   logic [31:0] dselect;
   logic [31:0] d_out;

   modport master (
      output rd_valid, ra, rb, abus, bbus, wr_valid, rw, wdata,
      input  rd_ready, asel, bsel, rd_data_valid, a_data, b_data,
             wr_ready, dselect, d_out
   );

   modport slave (
      input  rd_valid, ra, rb, abus, bbus, wr_valid, rw, wdata,
      output rd_ready, asel, bsel, rd_data_valid, a_data, b_data,
             wr_ready, dselect, d_out
   );
endinterface

// File: rtl/regbus_ctrl.sv
// Register-file bus controller: two-port read sequencing over shared tri-state
// buses, and a 2-entry write buffer drained with a falling-edge write strobe.
//
// Read FSM
//   state   | meaning
//   R_IDLE  | ready for a read request
//   R_DRIVE | asel/bsel enable the source registers onto abus/bbus
//   R_RESP  | a_data/b_data valid, rd_data_valid high
//
// Write FSM
//   state    | meaning
//   W_IDLE   | FIFO empty (or just filled), no strobe
//   W_STROBE | dselect high for the head entry; registers capture on negedge
//   W_HOLD   | d_out held, dselect low; head entry popped at end of cycle
module regbus_ctrl (
   input  logic     clk,
   input  logic     rst_n,
   regbus_if.slave  bus
);

   typedef enum logic [1:0] {R_IDLE, R_DRIVE, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_STROBE, W_HOLD} w_state_t;

   r_state_t    r_state_q, r_state_d;
   w_state_t    w_state_q, w_state_d;

   // FIFO entries are {rw, wdata}
   logic [36:0] mem_q [2];
   logic        wr_ptr_q, rd_ptr_q;
   logic [1:0]  cnt_q, cnt_d;
   logic [36:0] head_e, next_e;

   logic        rd_accept, wr_accept, pop;

   logic [31:0] asel_q, bsel_q;
   logic [31:0] a_data_q, b_data_q;
   logic        a_zero_q, b_zero_q;
   logic        fa_hit_q, fb_hit_q, fa_hit_d, fb_hit_d;
   logic [31:0] fa_data_q, fb_data_q, fa_data_d, fb_data_d;

   logic [31:0] d_out_q;
   logic [4:0]  wsel_q;
   logic        load_en;
   logic [36:0] load_e;

   assign head_e    = mem_q[rd_ptr_q];
   assign next_e    = mem_q[~rd_ptr_q];
   assign rd_accept = bus.rd_valid && (r_state_q == R_IDLE);
   assign wr_accept = bus.wr_valid && (cnt_q != 2'd2);
   assign pop       = (w_state_q == W_HOLD);
   assign cnt_d     = cnt_q + {1'b0, wr_accept} - {1'b0, pop};

   assign bus.wr_ready = (cnt_q != 2'd2);
   assign bus.asel     = asel_q;
   assign bus.bsel     = bsel_q;
   assign bus.a_data   = a_data_q;
   assign bus.b_data   = b_data_q;
   assign bus.d_out    = d_out_q;

   // Read FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state_q <= R_IDLE;
      else        r_state_q <= r_state_d;
   end

   // Read FSM next state and handshake outputs
   always_comb begin
      r_state_d         = r_state_q;
      bus.rd_ready      = 1'b0;
      bus.rd_data_valid = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            bus.rd_ready = 1'b1;
            if (bus.rd_valid) r_state_d = R_DRIVE;
         end
         R_DRIVE: r_state_d = R_RESP;
         R_RESP: begin
            bus.rd_data_valid = 1'b1;
            r_state_d         = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Forwarding lookup, oldest to newest so the newest match wins; the write
   // accepted on the same edge is the newest of all
   always_comb begin
      fa_hit_d  = 1'b0;
      fa_data_d = '0;
      fb_hit_d  = 1'b0;
      fb_data_d = '0;
      if (cnt_q != 2'd0 && head_e[36:32] == bus.ra) begin
         fa_hit_d  = 1'b1;
         fa_data_d = head_e[31:0];
      end
      if (cnt_q == 2'd2 && next_e[36:32] == bus.ra) begin
         fa_hit_d  = 1'b1;
         fa_data_d = next_e[31:0];
      end
      if (wr_accept && bus.rw == bus.ra) begin
         fa_hit_d  = 1'b1;
         fa_data_d = bus.wdata;
      end
      if (cnt_q != 2'd0 && head_e[36:32] == bus.rb) begin
         fb_hit_d  = 1'b1;
         fb_data_d = head_e[31:0];
      end
      if (cnt_q == 2'd2 && next_e[36:32] == bus.rb) begin
         fb_hit_d  = 1'b1;
         fb_data_d = next_e[31:0];
      end
      if (wr_accept && bus.rw == bus.rb) begin
         fb_hit_d  = 1'b1;
         fb_data_d = bus.wdata;
      end
   end

   // Read datapath: one-cycle bus enables, capture on the edge leaving R_DRIVE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asel_q    <= '0;
         bsel_q    <= '0;
         a_data_q  <= '0;
         b_data_q  <= '0;
         a_zero_q  <= 1'b0;
         b_zero_q  <= 1'b0;
         fa_hit_q  <= 1'b0;
         fb_hit_q  <= 1'b0;
         fa_data_q <= '0;
         fb_data_q <= '0;
      end else begin
         asel_q <= '0;
         bsel_q <= '0;
         if (rd_accept) begin
            asel_q    <= (bus.ra == 5'd0) ? 32'd0 : (32'd1 << bus.ra);
            bsel_q    <= (bus.rb == 5'd0) ? 32'd0 : (32'd1 << bus.rb);
            a_zero_q  <= (bus.ra == 5'd0);
            b_zero_q  <= (bus.rb == 5'd0);
            fa_hit_q  <= fa_hit_d;
            fb_hit_q  <= fb_hit_d;
            fa_data_q <= fa_data_d;
            fb_data_q <= fb_data_d;
         end
         if (r_state_q == R_DRIVE) begin
            a_data_q <= a_zero_q ? 32'd0 : (fa_hit_q ? fa_data_q : bus.abus);
            b_data_q <= b_zero_q ? 32'd0 : (fb_hit_q ? fb_data_q : bus.bbus);
         end
      end
   end

   // Write FIFO storage and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (wr_accept) begin
            mem_q[wr_ptr_q] <= {bus.rw, bus.wdata};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_d;
      end
   end

   // Write FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) w_state_q <= W_IDLE;
      else        w_state_q <= w_state_d;
   end

   // Write FSM next state, strobe decode and d_out load request
   always_comb begin
      w_state_d   = w_state_q;
      bus.dselect = '0;
      load_en     = 1'b0;
      load_e      = head_e;
      case (w_state_q)
         W_IDLE: begin
            if (cnt_q != 2'd0) begin
               w_state_d = W_STROBE;
               load_en   = 1'b1;
            end
         end
         W_STROBE: begin
            if (wsel_q != 5'd0) bus.dselect = 32'd1 << wsel_q;
            w_state_d = W_HOLD;
         end
         W_HOLD: begin
            // After the pop the new head is either the second stored entry
            // or the write landing on this same edge
            if (cnt_q == 2'd2) begin
               w_state_d = W_STROBE;
               load_en   = 1'b1;
               load_e    = next_e;
            end else if (wr_accept) begin
               w_state_d = W_STROBE;
               load_en   = 1'b1;
               load_e    = {bus.rw, bus.wdata};
            end else begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // d_out and strobe target change only on entry to W_STROBE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_out_q <= '0;
         wsel_q  <= '0;
      end else if (load_en) begin
         wsel_q  <= load_e[36:32];
         d_out_q <= load_e[31:0];
      end
   end

endmodule

// File: tb/tb_regbus_ctrl.sv
// Directed bench for regbus_ctrl with a behavioural 32-entry register array
// that captures d_out on the falling edge and drives the shared read buses.
module tb_regbus_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   regbus_if bus_if ();

   regbus_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   logic [31:0] regs [32] = '{default: 32'h0};
   int          wcnt [32] = '{default: 0};

   // Register array model: capture on negedge while selected
   always @(negedge clk) begin
      for (int i = 1; i < 32; i++) begin
         if (bus_if.dselect[i]) begin
            regs[i] = bus_if.d_out;
            wcnt[i] = wcnt[i] + 1;
         end
      end
   end

   // Shared read buses; an undriven bus reads as a marker value
   always_comb begin
      bus_if.abus = 32'hBAD0_BAD0;
      bus_if.bbus = 32'hBAD0_BAD0;
      for (int i = 0; i < 32; i++) begin
         if (bus_if.asel[i]) bus_if.abus = regs[i];
         if (bus_if.bsel[i]) bus_if.bbus = regs[i];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr_push(input logic [4:0] rw, input logic [31:0] wd);
      int budget;
      budget = 20;
      bus_if.wr_valid = 1'b1;
      bus_if.rw       = rw;
      bus_if.wdata    = wd;
      while (!bus_if.wr_ready && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) check_eq("wr_ready_timeout", {31'd0, bus_if.wr_ready}, 32'd1);
      tick();
      bus_if.wr_valid = 1'b0;
   endtask

   task automatic rd_req(input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] exp_a, input logic [31:0] exp_b,
                         input string tag);
      logic [31:0] ea, eb;
      ea = (a == 5'd0) ? 32'd0 : (32'd1 << a);
      eb = (b == 5'd0) ? 32'd0 : (32'd1 << b);
      check_eq({tag, "_rdy"}, {31'd0, bus_if.rd_ready}, 32'd1);
      bus_if.rd_valid = 1'b1;
      bus_if.ra       = a;
      bus_if.rb       = b;
      tick();
      bus_if.rd_valid = 1'b0;
      check_eq({tag, "_asel"}, bus_if.asel, ea);
      check_eq({tag, "_bsel"}, bus_if.bsel, eb);
      check_eq({tag, "_early_vld"}, {31'd0, bus_if.rd_data_valid}, 32'd0);
      tick();
      check_eq({tag, "_vld"}, {31'd0, bus_if.rd_data_valid}, 32'd1);
      check_eq({tag, "_a"}, bus_if.a_data, exp_a);
      check_eq({tag, "_b"}, bus_if.b_data, exp_b);
      check_eq({tag, "_sel_off"}, bus_if.asel | bus_if.bsel, 32'd0);
      tick();
      check_eq({tag, "_vld_end"}, {31'd0, bus_if.rd_data_valid}, 32'd0);
      check_eq({tag, "_a_hold"}, bus_if.a_data, exp_a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] sel_or;
      logic        vld_or;
      logic [5:0]  rdy_seen;
      logic        acc;
      int          k;

      bus_if.rd_valid = 1'b0;
      bus_if.ra       = '0;
      bus_if.rb       = '0;
      bus_if.wr_valid = 1'b0;
      bus_if.rw       = '0;
      bus_if.wdata    = '0;

      // Reset values
      #12;
      check_eq("rst_asel",    bus_if.asel, 32'd0);
      check_eq("rst_bsel",    bus_if.bsel, 32'd0);
      check_eq("rst_dselect", bus_if.dselect, 32'd0);
      check_eq("rst_d_out",   bus_if.d_out, 32'd0);
      check_eq("rst_a_data",  bus_if.a_data, 32'd0);
      check_eq("rst_b_data",  bus_if.b_data, 32'd0);
      check_eq("rst_rd_vld",  {31'd0, bus_if.rd_data_valid}, 32'd0);
      check_eq("rst_rd_rdy",  {31'd0, bus_if.rd_ready}, 32'd1);
      check_eq("rst_wr_rdy",  {31'd0, bus_if.wr_ready}, 32'd1);

      // First edge after release accepts a read
      @(negedge clk);
      rst_n = 1'b1;
      rd_req(5'd3, 5'd7, 32'd0, 32'd0, "rd_first");

      // Single write to r5 with cycle-level strobe checks
      wr_push(5'd5, 32'hDEAD_BEEF);
      check_eq("w5_idle_dsel", bus_if.dselect, 32'd0);
      tick();
      check_eq("w5_strobe_dsel", bus_if.dselect, 32'h0000_0020);
      check_eq("w5_strobe_dout", bus_if.d_out, 32'hDEAD_BEEF);
      tick();
      check_eq("w5_hold_dsel", bus_if.dselect, 32'd0);
      check_eq("w5_hold_dout", bus_if.d_out, 32'hDEAD_BEEF);
      tick();
      check_eq("w5_reg", regs[5], 32'hDEAD_BEEF);
      check_eq("w5_cnt", wcnt[5], 32'd1);

      // Bus reads of written registers
      wr_push(5'd3, 32'hA5A5_0003);
      wr_push(5'd7, 32'h0000_0007);
      idle(8);
      rd_req(5'd3, 5'd7, 32'hA5A5_0003, 32'h0000_0007, "rd37");
      rd_req(5'd5, 5'd3, 32'hDEAD_BEEF, 32'hA5A5_0003, "rd53");

      // Forwarding: r9 holds a stale 2 on the bus while 3 is still queued
      wr_push(5'd9, 32'd1);
      wr_push(5'd9, 32'd2);
      wr_push(5'd9, 32'd3);
      rd_req(5'd9, 5'd3, 32'd3, 32'hA5A5_0003, "fwd9");
      idle(10);
      check_eq("fwd9_reg", regs[9], 32'd3);
      check_eq("fwd9_cnt", wcnt[9], 32'd3);
      rd_req(5'd9, 5'd9, 32'd3, 32'd3, "rd99");

      // r0 write is a no-op strobe; r0 reads as zero
      sel_or = '0;
      wr_push(5'd0, 32'hFFFF_FFFF);
      for (int i = 0; i < 6; i++) begin
         sel_or = sel_or | bus_if.dselect;
         tick();
      end
      check_eq("r0_dselect", sel_or, 32'd0);
      check_eq("r0_dout", bus_if.d_out, 32'hFFFF_FFFF);
      rd_req(5'd0, 5'd0, 32'd0, 32'd0, "rd00");

      // FIFO full: wr_valid held for 6 cycles
      k = 0;
      rdy_seen = '0;
      bus_if.wr_valid = 1'b1;
      bus_if.rw       = 5'd10;
      bus_if.wdata    = 32'h1000_0010;
      for (int c = 0; c < 6; c++) begin
         rdy_seen[c] = bus_if.wr_ready;
         acc = bus_if.wr_ready;
         tick();
         if (acc) begin
            k++;
            bus_if.rw    = 5'(10 + k);
            bus_if.wdata = 32'h1000_0010 + 32'(k);
         end
      end
      bus_if.wr_valid = 1'b0;
      check_eq("full_rdy_pattern", {26'd0, rdy_seen}, 32'h0000_0013);
      check_eq("full_accepted", 32'(k), 32'd3);
      idle(12);
      check_eq("full_r10", regs[10], 32'h1000_0010);
      check_eq("full_r11", regs[11], 32'h1000_0011);
      check_eq("full_r12", regs[12], 32'h1000_0012);
      check_eq("full_cnt10", wcnt[10], 32'd1);
      check_eq("full_cnt11", wcnt[11], 32'd1);
      check_eq("full_cnt12", wcnt[12], 32'd1);
      check_eq("full_cnt13", wcnt[13], 32'd0);

      // Reset during W_STROBE with a second entry queued
      wr_push(5'd20, 32'hCAFE_0020);
      wr_push(5'd21, 32'hCAFE_0021);
      check_eq("rstw_strobe", bus_if.dselect, 32'h0010_0000);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rstw_dsel_async", bus_if.dselect, 32'd0);
      check_eq("rstw_dout", bus_if.d_out, 32'd0);
      check_eq("rstw_wr_rdy", {31'd0, bus_if.wr_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      sel_or = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         sel_or = sel_or | bus_if.dselect;
      end
      check_eq("rstw_flushed", sel_or, 32'd0);
      check_eq("rstw_r20", regs[20], 32'd0);
      check_eq("rstw_r21", regs[21], 32'd0);

      // Reset during R_DRIVE
      bus_if.rd_valid = 1'b1;
      bus_if.ra       = 5'd4;
      bus_if.rb       = 5'd6;
      tick();
      bus_if.rd_valid = 1'b0;
      check_eq("rstr_asel", bus_if.asel, 32'h0000_0010);
      check_eq("rstr_bsel", bus_if.bsel, 32'h0000_0040);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rstr_asel_async", bus_if.asel, 32'd0);
      check_eq("rstr_bsel_async", bus_if.bsel, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      vld_or = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         vld_or = vld_or | bus_if.rd_data_valid;
      end
      check_eq("rstr_no_resp", {31'd0, vld_or}, 32'd0);
      rd_req(5'd5, 5'd9, 32'hDEAD_BEEF, 32'd3, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
